// File: rtl/tl_ul_pkg.sv
// TileLink-UL shared definitions for the two-master arbiter slice.
// Opcodes, default widths and burst length helper.
package tl_ul_pkg;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  // Only Puts carry data beats; one beat is 4 bytes.
  function automatic int unsigned beats_of(
    input logic [2:0] opcode,
    input logic [2:0] size
  );
    int unsigned n;
    n = 1;
    if ((opcode == PUT_FULL || opcode == PUT_PARTIAL) &&
        size > 3'd2)
      n = 32'd1 << (size - 3'd2);
    return n;
  endfunction

endpackage

// File: rtl/tl_rr_pick2.sv
// Two-request round-robin picker.
// A lone requester wins; on a tie the master not served last wins.
module tl_rr_pick2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       grant
);

  always_comb begin
    grant = ~rr_last;
    unique case (1'b1)
      (req == 2'b01): grant = 1'b0;
      (req == 2'b10): grant = 1'b1;
      default:        grant = ~rr_last;
    endcase
  end

endmodule

// File: rtl/tl_ul_arb2.sv
// Two-master TileLink-UL A/D arbiter in front of the fragmenter.
// Round-robin A grant, locked across stalls and Put bursts.
module tl_ul_arb2 #(
  parameter int ADDR_W      = tl_ul_pkg::ADDR_W,
  parameter int DATA_W      = tl_ul_pkg::DATA_W,
  parameter int SRC_W       = 1,
  parameter int MAX_LGBEATS = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  in_a_valid,
  output logic [1:0]                  in_a_ready,
  input  logic [1:0][2:0]             in_a_opcode,
  input  logic [1:0][2:0]             in_a_param,
  input  logic [1:0][2:0]             in_a_size,
  input  logic [1:0][SRC_W-1:0]       in_a_source,
  input  logic [1:0][ADDR_W-1:0]      in_a_address,
  input  logic [1:0][3:0]             in_a_mask,
  input  logic [1:0][DATA_W-1:0]      in_a_data,
  output logic                        out_a_valid,
  input  logic                        out_a_ready,
  output logic [2:0]                  out_a_opcode,
  output logic [2:0]                  out_a_param,
  output logic [2:0]                  out_a_size,
  output logic [SRC_W:0]              out_a_source,
  output logic [ADDR_W-1:0]           out_a_address,
  output logic [3:0]                  out_a_mask,
  output logic [DATA_W-1:0]           out_a_data,
  input  logic                        out_d_valid,
  output logic                        out_d_ready,
  input  logic [2:0]                  out_d_opcode,
  input  logic [1:0]                  out_d_param,
  input  logic [2:0]                  out_d_size,
  input  logic [SRC_W:0]              out_d_source,
  input  logic                        out_d_denied,
  input  logic [DATA_W-1:0]           out_d_data,
  output logic [1:0]                  in_d_valid,
  input  logic [1:0]                  in_d_ready,
  output logic [2:0]                  in_d_opcode,
  output logic [1:0]                  in_d_param,
  output logic [2:0]                  in_d_size,
  output logic [SRC_W-1:0]            in_d_source,
  output logic                        in_d_denied,
  output logic [DATA_W-1:0]           in_d_data
);

  logic                   locked;
  logic                   owner;
  logic                   rr_last;
  logic [MAX_LGBEATS-1:0] beat_cnt;
  logic                   pick;
  logic                   grant;
  logic                   fire;
  logic                   last;
  logic                   sel;
  int unsigned            beats;

  tl_rr_pick2 u_pick (
    .req     (in_a_valid),
    .rr_last (rr_last),
    .grant   (pick)
  );

  assign grant = locked ? owner : pick;

  assign out_a_valid   = in_a_valid[grant];
  assign out_a_opcode  = in_a_opcode[grant];
  assign out_a_param   = in_a_param[grant];
  assign out_a_size    = in_a_size[grant];
  assign out_a_source  = {grant, in_a_source[grant]};
  assign out_a_address = in_a_address[grant];
  assign out_a_mask    = in_a_mask[grant];
  assign out_a_data    = in_a_data[grant];

  assign in_a_ready = grant ? {out_a_ready, 1'b0}
                            : {1'b0, out_a_ready};

  assign fire = out_a_valid & out_a_ready;

  always_comb begin
    beats = tl_ul_pkg::beats_of(out_a_opcode, out_a_size);
    last  = (beats == 1) || (32'(beat_cnt) == beats - 1);
  end

  // Any offered beat that does not close its message pins the grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      locked   <= 1'b0;
      owner    <= 1'b0;
      rr_last  <= 1'b1;
      beat_cnt <= '0;
    end else if (fire && last) begin
      locked   <= 1'b0;
      rr_last  <= grant;
      beat_cnt <= '0;
    end else if (out_a_valid) begin
      locked <= 1'b1;
      owner  <= grant;
      if (fire)
        beat_cnt <= beat_cnt + MAX_LGBEATS'(1);
    end
  end

  assign sel = out_d_source[SRC_W];

  assign in_d_valid  = {out_d_valid & sel, out_d_valid & ~sel};
  assign out_d_ready = in_d_ready[sel];
  assign in_d_opcode = out_d_opcode;
  assign in_d_param  = out_d_param;
  assign in_d_size   = out_d_size;
  assign in_d_source = out_d_source[SRC_W-1:0];
  assign in_d_denied = out_d_denied;
  assign in_d_data   = out_d_data;

endmodule

// File: tb/tb_tl_ul_arb2.sv
// Bench for tl_ul_arb2: directed scenarios with literal expectations,
// then random traffic against a message-level arbitration model.
module tb_tl_ul_arb2;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       in_a_valid;
  logic [1:0]       in_a_ready;
  logic [1:0][2:0]  in_a_opcode;
  logic [1:0][2:0]  in_a_param;
  logic [1:0][2:0]  in_a_size;
  logic [1:0][0:0]  in_a_source;
  logic [1:0][25:0] in_a_address;
  logic [1:0][3:0]  in_a_mask;
  logic [1:0][31:0] in_a_data;
  logic             out_a_valid;
  logic             out_a_ready;
  logic [2:0]       out_a_opcode;
  logic [2:0]       out_a_param;
  logic [2:0]       out_a_size;
  logic [1:0]       out_a_source;
  logic [25:0]      out_a_address;
  logic [3:0]       out_a_mask;
  logic [31:0]      out_a_data;
  logic             out_d_valid;
  logic             out_d_ready;
  logic [2:0]       out_d_opcode;
  logic [1:0]       out_d_param;
  logic [2:0]       out_d_size;
  logic [1:0]       out_d_source;
  logic             out_d_denied;
  logic [31:0]      out_d_data;
  logic [1:0]       in_d_valid;
  logic [1:0]       in_d_ready;
  logic [2:0]       in_d_opcode;
  logic [1:0]       in_d_param;
  logic [2:0]       in_d_size;
  logic [0:0]       in_d_source;
  logic             in_d_denied;
  logic [31:0]      in_d_data;

  int total = 0;
  int bad   = 0;

  tl_ul_arb2 dut (
    .clock         (clock),
    .reset         (reset),
    .in_a_valid    (in_a_valid),
    .in_a_ready    (in_a_ready),
    .in_a_opcode   (in_a_opcode),
    .in_a_param    (in_a_param),
    .in_a_size     (in_a_size),
    .in_a_source   (in_a_source),
    .in_a_address  (in_a_address),
    .in_a_mask     (in_a_mask),
    .in_a_data     (in_a_data),
    .out_a_valid   (out_a_valid),
    .out_a_ready   (out_a_ready),
    .out_a_opcode  (out_a_opcode),
    .out_a_param   (out_a_param),
    .out_a_size    (out_a_size),
    .out_a_source  (out_a_source),
    .out_a_address (out_a_address),
    .out_a_mask    (out_a_mask),
    .out_a_data    (out_a_data),
    .out_d_valid   (out_d_valid),
    .out_d_ready   (out_d_ready),
    .out_d_opcode  (out_d_opcode),
    .out_d_param   (out_d_param),
    .out_d_size    (out_d_size),
    .out_d_source  (out_d_source),
    .out_d_denied  (out_d_denied),
    .out_d_data    (out_d_data),
    .in_d_valid    (in_d_valid),
    .in_d_ready    (in_d_ready),
    .in_d_opcode   (in_d_opcode),
    .in_d_param    (in_d_param),
    .in_d_size     (in_d_size),
    .in_d_source   (in_d_source),
    .in_d_denied   (in_d_denied),
    .in_d_data     (in_d_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int tb_beats(input logic [2:0] op,
                                  input logic [2:0] sz);
    int n;
    n = 1;
    if (op <= 3'd1 && sz > 3'd2)
      n = 1 << (int'(sz) - 2);
    return n;
  endfunction

  task automatic set_m(input int i, input logic [2:0] op,
                       input logic [2:0] sz, input logic src,
                       input logic [25:0] adr,
                       input logic [31:0] dat);
    in_a_opcode[i]  = op;
    in_a_param[i]   = 3'd0;
    in_a_size[i]    = sz;
    in_a_source[i]  = src;
    in_a_address[i] = adr;
    in_a_mask[i]    = 4'hf;
    in_a_data[i]    = dat;
  endtask

  // model state: message-level arbitration
  logic m_last;
  logic m_hold;
  logic m_holder;
  int   m_left;
  // generator state per master
  logic g_act [2];
  int   g_left [2];

  initial begin
    logic [5:0]  rdy;
    logic [31:0] beat;
    logic        g;
    logic        ev;
    logic        fire;
    logic [1:0]  er;
    logic [1:0]  edv;

    reset        = 1'b0;
    in_a_valid   = 2'b00;
    in_a_opcode  = '0;
    in_a_param   = '0;
    in_a_size    = '0;
    in_a_source  = '0;
    in_a_address = '0;
    in_a_mask    = '0;
    in_a_data    = '0;
    out_a_ready  = 1'b0;
    out_d_valid  = 1'b0;
    out_d_opcode = '0;
    out_d_param  = '0;
    out_d_size   = '0;
    out_d_source = '0;
    out_d_denied = 1'b0;
    out_d_data   = '0;
    in_d_ready   = 2'b00;

    step();
    step();
    @(negedge clock);
    chk("rst_a_valid", 64'(out_a_valid), 64'd0);
    chk("rst_d_valid", 64'(in_d_valid), 64'd0);
    chk("rst_locked", 64'(dut.locked), 64'd0);
    chk("rst_rr_last", 64'(dut.rr_last), 64'd1);
    step();
    reset = 1'b1;

    // single Get from m0
    set_m(0, tl_ul_pkg::GET, 3'd2, 1'b1, 26'h100, 32'd0);
    in_a_valid  = 2'b01;
    out_a_ready = 1'b1;
    @(negedge clock);
    chk("t1_valid", 64'(out_a_valid), 64'd1);
    chk("t1_source", 64'(out_a_source), 64'h1);
    chk("t1_addr", 64'(out_a_address), 64'h100);
    chk("t1_ready", 64'(in_a_ready), 64'h1);
    step();
    in_a_valid = 2'b00;
    @(negedge clock);
    chk("t1_rr_last", 64'(dut.rr_last), 64'd0);
    chk("t1_locked", 64'(dut.locked), 64'd0);
    step();

    // both Get every cycle: m1, m0, m1, m0
    set_m(1, tl_ul_pkg::GET, 3'd2, 1'b0, 26'h200, 32'd0);
    in_a_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t2_owner", 64'(out_a_source[1]),
          (k % 2 == 0) ? 64'd1 : 64'd0);
      chk("t2_ready", 64'(in_a_ready),
          (k % 2 == 0) ? 64'h2 : 64'h1);
      step();
    end
    in_a_valid = 2'b00;

    // m0 4-beat PutFull, m1 joins after beat 0
    rdy  = 6'b101101;
    beat = 32'd0;
    set_m(0, tl_ul_pkg::PUT_FULL, 3'd4, 1'b0, 26'h40, beat);
    in_a_valid = 2'b01;
    for (int c = 0; c < 6; c++) begin
      out_a_ready = rdy[c];
      if (c == 1) in_a_valid = 2'b11;
      @(negedge clock);
      chk("t3_ready", 64'(in_a_ready), 64'({1'b0, rdy[c]}));
      chk("t3_owner", 64'(out_a_source[1]), 64'd0);
      chk("t3_data", 64'(out_a_data), 64'(beat));
      step();
      if (rdy[c]) beat = beat + 1;
      in_a_data[0] = beat;
    end
    set_m(0, tl_ul_pkg::GET, 3'd2, 1'b0, 26'h80, 32'd0);
    out_a_ready = 1'b1;
    @(negedge clock);
    chk("t3_handoff", 64'(out_a_source[1]), 64'd1);
    chk("t3_handoff_rdy", 64'(in_a_ready), 64'h2);
    step();
    in_a_valid = 2'b00;

    // stall holds m1 even though m0 would win a fresh tie
    set_m(1, tl_ul_pkg::GET, 3'd2, 1'b1, 26'h3a4, 32'd0);
    in_a_valid  = 2'b10;
    out_a_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) in_a_valid = 2'b11;
      @(negedge clock);
      chk("t4_owner", 64'(out_a_source[1]), 64'd1);
      chk("t4_addr", 64'(out_a_address), 64'h3a4);
      chk("t4_ready", 64'(in_a_ready), 64'h0);
      step();
    end
    out_a_ready = 1'b1;
    @(negedge clock);
    chk("t4_fire", 64'(in_a_ready), 64'h2);
    step();
    @(negedge clock);
    chk("t4_next", 64'(in_a_ready), 64'h1);
    step();
    in_a_valid = 2'b00;

    // D routing by source tag
    out_d_valid  = 1'b1;
    out_d_source = 2'b10;
    out_d_opcode = tl_ul_pkg::ACK_DATA;
    out_d_data   = 32'hcafef00d;
    in_d_ready   = 2'b01;
    #1;
    chk("t5_dvalid", 64'(in_d_valid), 64'h2);
    chk("t5_dready0", 64'(out_d_ready), 64'd0);
    chk("t5_dsrc", 64'(in_d_source), 64'd0);
    chk("t5_ddata", 64'(in_d_data), 64'hcafef00d);
    in_d_ready = 2'b11;
    #1;
    chk("t5_dready1", 64'(out_d_ready), 64'd1);
    out_d_valid = 1'b0;
    in_d_ready  = 2'b00;

    // reset in the middle of a 4-beat Put
    set_m(0, tl_ul_pkg::PUT_FULL, 3'd4, 1'b0, 26'h0, 32'd0);
    in_a_valid  = 2'b01;
    out_a_ready = 1'b1;
    step();
    step();
    chk("t6_cnt_mid", 64'(dut.beat_cnt), 64'd2);
    chk("t6_lock_mid", 64'(dut.locked), 64'd1);
    reset = 1'b0;
    #1;
    chk("t6_lock_rst", 64'(dut.locked), 64'd0);
    chk("t6_cnt_rst", 64'(dut.beat_cnt), 64'd0);
    in_a_valid = 2'b00;
    step();
    reset = 1'b1;
    set_m(0, tl_ul_pkg::GET, 3'd2, 1'b0, 26'h10, 32'd0);
    in_a_valid = 2'b01;
    @(negedge clock);
    chk("t6_get_rdy", 64'(in_a_ready), 64'h1);
    step();
    chk("t6_get_lock", 64'(dut.locked), 64'd0);
    chk("t6_get_cnt", 64'(dut.beat_cnt), 64'd0);
    in_a_valid = 2'b00;

    // random traffic against the model
    reset = 1'b0;
    step();
    reset    = 1'b1;
    m_last   = 1'b1;
    m_hold   = 1'b0;
    m_holder = 1'b0;
    m_left   = 0;
    for (int i = 0; i < 2; i++) begin
      g_act[i]  = 1'b0;
      g_left[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!g_act[i] && $urandom_range(0, 2) != 0) begin
          case ($urandom_range(0, 2))
            0: in_a_opcode[i] = tl_ul_pkg::PUT_FULL;
            1: in_a_opcode[i] = tl_ul_pkg::PUT_PARTIAL;
            default: in_a_opcode[i] = tl_ul_pkg::GET;
          endcase
          in_a_size[i] = (in_a_opcode[i] == tl_ul_pkg::GET)
                       ? 3'($urandom_range(0, 2))
                       : 3'($urandom_range(0, 4));
          in_a_param[i]   = 3'($urandom);
          in_a_source[i]  = 1'($urandom);
          in_a_address[i] = 26'($urandom);
          in_a_mask[i]    = 4'($urandom);
          in_a_data[i]    = $urandom;
          g_left[i] = tb_beats(in_a_opcode[i], in_a_size[i]);
          g_act[i]  = 1'b1;
        end
        in_a_valid[i] = g_act[i];
      end
      out_a_ready  = ($urandom_range(0, 3) != 0);
      out_d_valid  = 1'($urandom);
      out_d_source = 2'($urandom);
      out_d_opcode = 3'($urandom);
      out_d_param  = 2'($urandom);
      out_d_size   = 3'($urandom);
      out_d_denied = 1'($urandom);
      out_d_data   = $urandom;
      in_d_ready   = 2'($urandom);

      @(negedge clock);
      if (m_hold)                 g = m_holder;
      else if (in_a_valid == 2'b01) g = 1'b0;
      else if (in_a_valid == 2'b10) g = 1'b1;
      else                        g = ~m_last;
      ev   = in_a_valid[g];
      er   = g ? {out_a_ready, 1'b0} : {1'b0, out_a_ready};
      fire = ev & out_a_ready;
      chk("r_a_valid", 64'(out_a_valid), 64'(ev));
      chk("r_a_ready", 64'(in_a_ready), 64'(er));
      if (ev) begin
        chk("r_a_hdr",
            64'({out_a_opcode, out_a_param, out_a_size,
                 out_a_source}),
            64'({in_a_opcode[g], in_a_param[g], in_a_size[g],
                 g, in_a_source[g]}));
        chk("r_a_addr", 64'(out_a_address),
            64'(in_a_address[g]));
        chk("r_a_mask_data", 64'({out_a_mask, out_a_data}),
            64'({in_a_mask[g], in_a_data[g]}));
      end
      edv = !out_d_valid ? 2'b00
          : (out_d_source[1] ? 2'b10 : 2'b01);
      chk("r_d_valid", 64'(in_d_valid), 64'(edv));
      chk("r_d_ready", 64'(out_d_ready),
          64'(in_d_ready[out_d_source[1]]));
      chk("r_d_fields",
          64'({in_d_opcode, in_d_param, in_d_size,
               in_d_source, in_d_denied}),
          64'({out_d_opcode, out_d_param, out_d_size,
               out_d_source[0], out_d_denied}));
      chk("r_d_data", 64'(in_d_data), 64'(out_d_data));

      step();
      if (ev) begin
        if (fire) begin
          if (m_left == 0)
            m_left = tb_beats(in_a_opcode[g], in_a_size[g]);
          m_left--;
          if (m_left == 0) begin
            m_hold = 1'b0;
            m_last = g;
          end else begin
            m_hold   = 1'b1;
            m_holder = g;
          end
          g_left[g]--;
          in_a_data[g] = $urandom;
          if (g_left[g] == 0) g_act[g] = 1'b0;
        end else begin
          m_hold   = 1'b1;
          m_holder = g;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_ul_arb2.md
Name: tl_ul_arb2

Overview:
- Two-master TileLink-UL arbiter that shares the single A/D port of the TL fragmenter between the core's instruction-fetch master (m0) and data/debug master (m1).
- Arbitrates A channel round-robin and locks the grant for multi-beat Put bursts.
- Widens source ID by one bit to tag the owning master; routes D responses back by that tag.
- Sits directly upstream of the fragmenter; downstream port widths match its A/D interface.

Parameters:
- ADDR_W, 26, A-channel address width
- DATA_W, 32, data width; beat bytes = DATA_W/8
- SRC_W, 1, upstream source width; downstream source is SRC_W+1
- MAX_LGBEATS, 3, log2 of max beats per burst; beat counter width

Ports:
- clock  in  1  single block clock
- reset  in  1  asynchronous, active-low reset
- in_a_valid  in  2  per-master A valid, bit i = master i
- in_a_ready  out  2  per-master A ready
- in_a_opcode/param/size  in  2x3 each  packed {m1,m0}
- in_a_source  in  2xSRC_W  packed
- in_a_address  in  2xADDR_W  packed
- in_a_mask  in  2x4  packed
- in_a_data  in  2xDATA_W  packed
- out_a_valid  out  1  / out_a_ready  in  1  to fragmenter
- out_a_opcode/param/size  out  3 each
- out_a_source  out  SRC_W+1  = {owner, in source}
- out_a_address  out  ADDR_W
- out_a_mask  out  4
- out_a_data  out  DATA_W
- out_d_valid  in  1  / out_d_ready  out  1
- out_d_opcode  in  3
- out_d_param  in  2
- out_d_size  in  3
- out_d_source  in  SRC_W+1
- out_d_denied  in  1
- out_d_data  in  DATA_W
- in_d_valid  out  2  / in_d_ready  in  2
- in_d_opcode  out  3
- in_d_param  out  2
- in_d_size  out  3
- in_d_source  out  SRC_W
- in_d_denied  out  1
- in_d_data  out  DATA_W
- The in_d_* fields other than in_d_valid are shared by both masters.

Behaviour:
- State registers: locked, owner, rr_last, beat_cnt[MAX_LGBEATS-1:0].
- Reset (reset=0, async) values:
  - locked=0, owner=0, rr_last=1, beat_cnt=0.
  - With in_a_valid=0, all valid outputs are 0.
- Grant when locked=0 (combinational, zero latency):
  - Only one master valid: that master wins.
  - Both valid: the master != rr_last wins.
- Grant when locked=1: owner wins.
- A path:
  - out_a_valid = in_a_valid[grant]; out_a_* muxed from grant.
  - in_a_ready[grant] = out_a_ready; the other master's ready = 0.
  - fire = out_a_valid & out_a_ready.
- Beats per message:
  - PutFull (0) or PutPartial (1) with size>2: 2^(size-2) beats.
  - Otherwise (Get=4, size<=2): 1 beat.
  - size > 2+MAX_LGBEATS is an upstream protocol violation and is not handled.
- last = (beats==1) | (beat_cnt==beats-1).
- Lock rules:
  - A presented but unaccepted beat must stay stable. Therefore locked<=1 and owner<=grant whenever out_a_valid & !(fire & last).
  - On fire & last: locked<=0, rr_last<=grant, beat_cnt<=0.
  - On fire & !last: beat_cnt++.
- Handoff: the new arbitration is evaluated the cycle after the last beat; no bubble is required beyond that.
- D path:
  - sel = out_d_source[SRC_W].
  - in_d_valid[sel] = out_d_valid; out_d_ready = in_d_ready[sel].
  - in_d_source = out_d_source[SRC_W-1:0]; other D fields pass through unregistered.
  - D routing is independent of A state; simultaneous A and D traffic is allowed.
- Reset mid-burst clears the lock immediately. Upstream masters are reset in the same domain, so no partial burst resumes.

Decomposition:
- Package tl_ul_pkg holds:
  - opcode constants PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACK=0, ACK_DATA=1
  - a beats-from-size function
  - width constants ADDR_W, DATA_W
- One sub-module, tl_rr_pick2: two-request round-robin picker (inputs req[1:0], rr_last; output grant).
- Everything else stays inline.

Test Plan:
- Reset released, only m0 issues Get size=2 addr 0x100 → out_a_source={0,src}, one beat; rr_last becomes 0.
- m0 and m1 both Get every cycle, out_a_ready=1 → grants alternate m1,m0,m1,... (first winner m1, since rr_last=0 after the previous test); no cycle with both in_a_ready high.
- m0 PutFull size=4 (4 beats) while m1 requests; ready toggles 1,0,1,1,0,1 → m0 holds the grant for all 4 beats, m1 granted the cycle after the 4th fire.
- out_a_valid with out_a_ready=0 for 3 cycles while the other master asserts valid → grant and out_a_* stay stable; no switch.
- D response with source=2'b10, in_d_ready=2'b01 → in_d_valid=2'b10 and out_d_ready=0 until in_d_ready[1]=1; in_d_source=0.
- Reset asserted after beat 2 of a 4-beat Put → locked=0 and beat_cnt=0 immediately; after release, the next single Get completes in 1 beat.
